hack_cpu: RTL and testbench

Multi-cycle Hack CPU core that generates the zx/nx/zy/ny/f/no control word for the 16-bit `alu` and consumes its out/zr/ng results. It fetches instructions from a synchronous instruction ROM and decodes A- and C-instructions. It holds the A, D and PC registers and reads and writes data memory through a synchronous RAM port. It sits between the instruction ROM, the data RAM / memory-mapped I/O, and the `alu` instance.

---
 rtl/hack_pkg.sv | 40 ++++
 rtl/alu.sv | 31 +++
 rtl/hack_cpu.sv | 123 ++++++++++++
 tb/tb_hack_cpu.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU core: FSM states, instruction field
// positions, destination/jump encodings and the jump condition helper.
package hack_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2
    } state_e;

    localparam int IS_C    = 15;
    localparam int A_BIT   = 12;
    localparam int CMP_HI  = 11;
    localparam int CMP_LO  = 6;
    localparam int DEST_HI = 5;
    localparam int DEST_LO = 3;
    localparam int JMP_HI  = 2;
    localparam int JMP_LO  = 0;

    localparam int DEST_A = 5;
    localparam int DEST_D = 4;
    localparam int DEST_M = 3;

    localparam logic [2:0] JGT = 3'b001;
    localparam logic [2:0] JEQ = 3'b010;
    localparam logic [2:0] JGE = 3'b011;
    localparam logic [2:0] JLT = 3'b100;
    localparam logic [2:0] JNE = 3'b101;
    localparam logic [2:0] JLE = 3'b110;
    localparam logic [2:0] JMP = 3'b111;

    localparam logic [14:0] RESET_PC_DEFAULT = 15'h0000;

    // Each jump bit selects one of the three disjoint sign classes of out.
    function automatic logic jump_taken(input logic [2:0] jmp,
                                        input logic zr, input logic ng);
        return (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/alu.sv
// 16-bit Hack ALU: optional zero/negate of each input, add or AND,
// optional negate of the result, with zero and negative flags.
module alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x1_s, x2_s, y1_s, y2_s, f_s;

    // Input conditioning, function select and output negation.
    always_comb begin
        x1_s = zx ? 16'h0000 : x;
        x2_s = nx ? ~x1_s : x1_s;
        y1_s = zy ? 16'h0000 : y;
        y2_s = ny ? ~y1_s : y1_s;
        f_s  = f ? (x2_s + y2_s) : (x2_s & y2_s);
        out  = no ? ~f_s : f_s;
        zr   = (out == 16'h0000);
        ng   = out[15];
    end

endmodule

// File: rtl/hack_cpu.sv
// Multi-cycle Hack CPU core: FETCH -> DECODE -> (EXEC) -> FETCH, with A, D,
// PC and IR registers, a synchronous ROM fetch port and a synchronous RAM port.
module hack_cpu
    import hack_pkg::*;
#(
    parameter logic [14:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [14:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [14:0] ram_addr,
    output logic        ram_rd,
    input  logic [15:0] ram_rdata,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    output logic [14:0] pc
);

    state_e      state_r, state_nxt_s;
    logic [15:0] a_r, d_r, ir_r;
    logic [14:0] pc_r;
    logic [14:0] pc_inc_s;
    logic [15:0] alu_y_s, alu_out_s;
    logic        alu_zr_s, alu_ng_s;
    logic        take_s;
    logic        ram_rd_s, ram_we_s;

    assign pc_inc_s = pc_r + 15'd1;
    assign alu_y_s  = ir_r[A_BIT] ? ram_rdata : a_r;
    assign take_s   = jump_taken(ir_r[JMP_HI:JMP_LO], alu_zr_s, alu_ng_s);

    alu u_alu (
        .x   (d_r),
        .y   (alu_y_s),
        .zx  (ir_r[11]),
        .nx  (ir_r[10]),
        .zy  (ir_r[9]),
        .ny  (ir_r[8]),
        .f   (ir_r[7]),
        .no  (ir_r[6]),
        .out (alu_out_s),
        .zr  (alu_zr_s),
        .ng  (alu_ng_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: A-instructions skip EXEC.
    always_comb begin
        state_nxt_s = FETCH;
        case (state_r)
            FETCH:   state_nxt_s = DECODE;
            DECODE:  state_nxt_s = rom_data[IS_C] ? EXEC : FETCH;
            EXEC:    state_nxt_s = FETCH;
            default: state_nxt_s = FETCH;
        endcase
    end

    // Datapath registers; EXEC reads the pre-edge A for both jump and M address.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r  <= 16'h0000;
            d_r  <= 16'h0000;
            ir_r <= 16'h0000;
            pc_r <= RESET_PC;
        end else begin
            case (state_r)
                FETCH: begin
                end
                DECODE: begin
                    ir_r <= rom_data;
                    if (!rom_data[IS_C]) begin
                        a_r  <= rom_data;
                        pc_r <= pc_inc_s;
                    end
                end
                EXEC: begin
                    if (ir_r[DEST_A]) a_r <= alu_out_s;
                    if (ir_r[DEST_D]) d_r <= alu_out_s;
                    pc_r <= take_s ? a_r[14:0] : pc_inc_s;
                end
                default: begin
                end
            endcase
        end
    end

    // Memory strobes; suppressed while reset is asserted so an aborted
    // instruction cannot touch RAM.
    always_comb begin
        ram_rd_s = 1'b0;
        ram_we_s = 1'b0;
        if (reset) begin
            ram_rd_s = 1'b0;
            ram_we_s = 1'b0;
        end else begin
            case (state_r)
                DECODE:  ram_rd_s = rom_data[IS_C] & rom_data[A_BIT];
                EXEC:    ram_we_s = ir_r[DEST_M];
                default: begin
                    ram_rd_s = 1'b0;
                    ram_we_s = 1'b0;
                end
            endcase
        end
    end

    assign ram_rd    = ram_rd_s;
    assign ram_we    = ram_we_s;
    assign ram_wdata = alu_out_s;
    assign ram_addr  = reset ? 15'h0000 : a_r[14:0];
    assign rom_addr  = reset ? RESET_PC : pc_r;
    assign pc        = reset ? RESET_PC : pc_r;

endmodule

// File: tb/tb_hack_cpu.sv
// Self-checking bench for hack_cpu: behavioural ROM/RAM, a scoreboard of
// expected RAM writes, and one task per scenario.
`timescale 1ns/1ps
module tb_hack_cpu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic [14:0] ram_addr;
    logic        ram_rd;
    logic [15:0] ram_rdata;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [14:0] pc;

    logic [15:0] rom [0:32767];
    logic [15:0] ram [0:32767];
    logic [30:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    always #5 clk = ~clk;

    hack_cpu dut (
        .clk       (clk),
        .reset     (reset),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ram_addr  (ram_addr),
        .ram_rd    (ram_rd),
        .ram_rdata (ram_rdata),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .pc        (pc)
    );

    always @(posedge clk) begin
        rom_data <= rom[rom_addr];
        if (ram_rd) ram_rdata <= ram[ram_addr];
        if (ram_we) ram[ram_addr] <= ram_wdata;
    end

    // Scoreboard: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt = we_cnt + 1;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_write addr=%h data=%h", ram_addr, ram_wdata);
            end else begin
                logic [30:0] e;
                e = exp_q.pop_front();
                if ({ram_addr, ram_wdata} !== e) begin
                    errors = errors + 1;
                    $display("FAIL ram_write got addr=%h data=%h expected addr=%h data=%h",
                             ram_addr, ram_wdata, e[30:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic clear_mem();
        for (int i = 0; i < 32768; i++) begin
            rom[i] = 16'h0000;
            ram[i] = 16'h0000;
        end
        exp_q.delete();
        we_cnt = 0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset two edges, then release in what becomes the first FETCH cycle.
    task automatic start();
        reset = 1'b1;
        run(2);
        reset = 1'b0;
    endtask

    task automatic chk15(input string name, input logic [14:0] got, input logic [14:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic chk_drained(input string name);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL %s pending_writes got=%0d expected=0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        clear_mem();
        rom[0] = 16'h0007;
        rom[1] = 16'hEEC8;
        ram[7] = 16'h1234;
        start();
        chk15("reset_pc", pc, 15'h0000);
        chk15("reset_rom_addr", rom_addr, 15'h0000);
        run(4);
        chk15("exec_ram_addr", ram_addr, 15'h0007);
        reset = 1'b1;
        #1;
        checks = checks + 1;
        if (ram_we !== 1'b0 || ram_rd !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_strobes got we=%b rd=%b expected we=0 rd=0", ram_we, ram_rd);
        end
        chk15("reset_ram_addr_during", ram_addr, 15'h0000);
        run(1);
        chk15("reset_pc_after", pc, 15'h0000);
        chk15("reset_ram_addr_after", ram_addr, 15'h0000);
        reset = 1'b0;
        #1;
        chk15("reset_rom_addr_after", rom_addr, 15'h0000);
        chk16("reset_no_write", ram[7], 16'h1234);
        chk_drained("reset");
    endtask

    task automatic test_load_store();
        clear_mem();
        rom[0] = 16'h0015;
        rom[1] = 16'hEC10;
        rom[2] = 16'h0064;
        rom[3] = 16'hE308;
        exp_q.push_back({15'd100, 16'h0015});
        start();
        run(10);
        chk15("ls_pc", pc, 15'd4);
        chk16("ls_ram100", ram[100], 16'h0015);
        chk16("ls_we_cycles", we_cnt[15:0], 16'd1);
        chk_drained("ls");
    endtask

    task automatic test_rmw();
        clear_mem();
        rom[0] = 16'h0005;
        rom[1] = 16'hFDC8;
        ram[5] = 16'h0007;
        exp_q.push_back({15'd5, 16'h0008});
        start();
        run(3);
        chk16("rmw_rd_in_decode", {15'h0000, ram_rd}, 16'h0001);
        chk15("rmw_rd_addr", ram_addr, 15'd5);
        run(2);
        chk15("rmw_pc", pc, 15'd2);
        chk16("rmw_ram5", ram[5], 16'h0008);
        chk_drained("rmw");
    endtask

    task automatic test_jumps();
        clear_mem();
        rom[0] = 16'h0028;
        rom[1] = 16'hE302;
        start();
        run(5);
        chk15("jeq_taken_pc", pc, 15'd40);
        clear_mem();
        rom[0] = 16'hEE90;
        rom[1] = 16'h0028;
        rom[2] = 16'hE301;
        rom[3] = 16'hEA87;
        start();
        run(8);
        chk15("jgt_not_taken_pc", pc, 15'd3);
        run(3);
        chk15("jmp_pc", pc, 15'd40);
        chk15("jmp_rom_addr", rom_addr, 15'd40);
        chk_drained("jumps");
    endtask

    task automatic test_simultaneous();
        clear_mem();
        rom[0]  = 16'h000A;
        rom[1]  = 16'hEDE8;
        rom[2]  = 16'h000C;
        rom[3]  = 16'hEC07;
        rom[12] = 16'hEDEF;
        exp_q.push_back({15'd10, 16'd11});
        exp_q.push_back({15'd12, 16'd13});
        start();
        run(5);
        chk15("am_pc", pc, 15'd2);
        chk15("am_new_a", ram_addr, 15'd11);
        chk16("am_ram10", ram[10], 16'd11);
        run(5);
        chk15("ajmp_pc", pc, 15'd12);
        run(3);
        chk15("am_jmp_old_a_pc", pc, 15'd12);
        chk15("am_jmp_new_a", ram_addr, 15'd13);
        chk16("am_jmp_ram12", ram[12], 16'd13);
        chk_drained("simultaneous");
    endtask

    task automatic test_pc_wrap();
        clear_mem();
        rom[0]       = 16'h7FFF;
        rom[1]       = 16'hEA87;
        rom[15'h7FFF] = 16'h0003;
        start();
        run(5);
        chk15("wrap_at_top", pc, 15'h7FFF);
        run(2);
        chk15("wrap_pc", pc, 15'h0000);
        chk15("wrap_a", ram_addr, 15'h0003);
        chk_drained("wrap");
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_rmw();
        test_jumps();
        test_simultaneous();
        test_pc_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
